// File: rtl/sample_reader_if.sv
// Bundle between sample_reader, the sample memory read port and the uart_tx mux.
// master = the reader itself; slave = the environment (watcher, memory, UART).
interface sample_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  activate;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic                  tx_active;
    logic                  tx_done;

    modport master (
        input  activate, mem_data, tx_active, tx_done,
        output done, mem_addr, mem_oe, tx_data, tx_start
    );

    modport slave (
        output activate, mem_data, tx_active, tx_done,
        input  done, mem_addr, mem_oe, tx_data, tx_start
    );
endinterface

// File: rtl/sample_reader.sv
// Streams header, COUNT sample bytes from address 0 and an 8-bit additive
// checksum of the samples to uart_tx, one byte per tx_start/tx_done round trip.
module sample_reader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    COUNT      = 256,
    parameter logic [DATA_WIDTH-1:0] HEADER     = 8'h22
) (
    input  logic            clk_50mhz,
    input  logic            reset,
    sample_reader_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;
    typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_SUM} phase_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COUNT - 1);

    state_t                r_state, w_state_next;
    phase_t                r_phase, w_phase_next;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
    logic [DATA_WIDTH-1:0] r_sum,   w_sum_next;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_next;
    logic                  r_tx_start, w_tx_start_next;
    logic                  r_done,  w_done_next;
    logic                  r_mem_oe, w_mem_oe_next;

    // NOTE: every variable gets a hold/default value before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_phase_next    = r_phase;
        w_addr_next     = r_addr;
        w_sum_next      = r_sum;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_done_next     = r_done;

        case (r_state)
            S_IDLE: begin
                w_done_next = 1'b0;
                if (bus.activate) begin
                    w_addr_next  = '0;
                    w_sum_next   = '0;
                    w_phase_next = PH_HDR;
                    w_state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!bus.activate) begin
                    w_state_next = S_IDLE;
                end else if (!bus.tx_active) begin
                    w_tx_start_next = 1'b1;
                    w_state_next    = S_WAIT;
                    case (r_phase)
                        PH_DATA: begin
                            w_tx_data_next = bus.mem_data;
                            w_sum_next     = r_sum + bus.mem_data;
                        end
                        PH_SUM:  w_tx_data_next = r_sum;
                        default: w_tx_data_next = HEADER;
                    endcase
                end
            end

            S_WAIT: begin
                if (bus.tx_done) begin
                    if (!bus.activate) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_ISSUE;
                        case (r_phase)
                            PH_HDR: w_phase_next = PH_DATA;
                            PH_DATA: begin
                                if (r_addr == LAST_ADDR) w_phase_next = PH_SUM;
                                else                     w_addr_next  = r_addr + 1'b1;
                            end
                            default: w_state_next = S_FIN;
                        endcase
                    end
                end
            end

            S_FIN: begin
                // Stays here while activate is high; a new frame needs a fresh rise.
                if (!bus.activate) begin
                    w_done_next  = 1'b0;
                    w_state_next = S_IDLE;
                end else begin
                    w_done_next = 1'b1;
                end
            end

            default: w_state_next = S_IDLE;
        endcase

        w_mem_oe_next = (w_state_next == S_ISSUE) || (w_state_next == S_WAIT);
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            r_phase    <= PH_HDR;
            r_addr     <= '0;
            r_sum      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            r_mem_oe   <= 1'b0;
        end else begin
            r_phase    <= w_phase_next;
            r_addr     <= w_addr_next;
            r_sum      <= w_sum_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_done     <= w_done_next;
            r_mem_oe   <= w_mem_oe_next;
        end
    end

    assign bus.mem_addr = r_addr;
    assign bus.mem_oe   = r_mem_oe;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_start = r_tx_start;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_sample_reader.sv
// Bench for sample_reader: memory and UART models per instance, frames compared
// against a reference built from the frame rules (header, samples, byte sum).
module tb_sample_reader;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk_50mhz = 1'b0;
    logic reset     = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    sample_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    sample_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    sample_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT(256), .HEADER(8'h22)) dut0 (
        .clk_50mhz(clk_50mhz), .reset(reset), .bus(bus0)
    );
    sample_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT(4), .HEADER(8'h22)) dut1 (
        .clk_50mhz(clk_50mhz), .reset(reset), .bus(bus1)
    );

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    assign bus0.mem_data = mem0[bus0.mem_addr];
    assign bus1.mem_data = mem1[bus1.mem_addr];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int   starts0 = 0, starts1 = 0;
    int   cnt0 = 0, cnt1 = 0;
    logic busy0 = 1'b0, busy1 = 1'b0, force0 = 1'b0;
    assign bus0.tx_active = busy0 | force0;
    assign bus1.tx_active = busy1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART models: log each started byte, report done 10 cycles later.
    always @(negedge clk_50mhz) begin
        bus0.tx_done = 1'b0;
        if (bus0.tx_start) begin
            check("start_while_busy0", 32'(bus0.tx_active), 32'd0);
            q0.push_back(bus0.tx_data);
            starts0++;
            cnt0  = 10;
            busy0 = 1'b1;
        end else if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin
                bus0.tx_done = 1'b1;
                busy0        = 1'b0;
            end
        end
    end

    always @(negedge clk_50mhz) begin
        bus1.tx_done = 1'b0;
        if (bus1.tx_start) begin
            check("start_while_busy1", 32'(bus1.tx_active), 32'd0);
            q1.push_back(bus1.tx_data);
            starts1++;
            cnt1  = 10;
            busy1 = 1'b1;
        end else if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin
                bus1.tx_done = 1'b1;
                busy1        = 1'b0;
            end
        end
    end

    task automatic clear_log(input int which);
        if (which == 0) begin q0.delete(); starts0 = 0; end
        else            begin q1.delete(); starts1 = 0; end
    endtask

    task automatic wait_done(input int which, input int budget, input string tag);
        int k = 0;
        logic d;
        d = (which == 0) ? bus0.done : bus1.done;
        while (!d && k < budget) begin
            @(negedge clk_50mhz);
            k++;
            d = (which == 0) ? bus0.done : bus1.done;
        end
        check(tag, 32'(d), 32'd1);
    endtask

    task automatic wait_starts0(input int n, input int budget, input string tag);
        int k = 0;
        while (starts0 < n && k < budget) begin
            @(negedge clk_50mhz);
            k++;
        end
        check(tag, 32'(starts0 >= n), 32'd1);
    endtask

    // Reference frame: header, COUNT samples from address 0, sum of samples mod 256.
    task automatic check_frame(input int which, input int count, input string tag);
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        int s = 0;
        exp_q.push_back(8'h22);
        for (int i = 0; i < count; i++) begin
            int b;
            b = (which == 0) ? int'(mem0[i]) : int'(mem1[i]);
            exp_q.push_back(8'(b));
            s += b;
        end
        exp_q.push_back(8'(s % 256));
        got_q = (which == 0) ? q0 : q1;
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic run_frame0(input string tag);
        clear_log(0);
        bus0.activate = 1'b1;
        wait_done(0, 8000, {tag, "_done"});
        check_frame(0, 256, tag);
        bus0.activate = 1'b0;
        @(negedge clk_50mhz);
    endtask

    initial begin
        bus0.activate = 1'b0;
        bus1.activate = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'(i);
            mem1[i] = 8'h00;
        end

        repeat (3) @(negedge clk_50mhz);
        check("rst_done",     32'(bus0.done),     32'd0);
        check("rst_tx_start", 32'(bus0.tx_start), 32'd0);
        check("rst_mem_oe",   32'(bus0.mem_oe),   32'd0);
        check("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
        check("rst_tx_data",  32'(bus0.tx_data),  32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk_50mhz);

        // Ramp memory, COUNT=256, with start latency checks.
        clear_log(0);
        bus0.activate = 1'b1;
        @(negedge clk_50mhz);
        check("lat_oe_issue", 32'(bus0.mem_oe),   32'd1);
        check("lat_no_start", 32'(bus0.tx_start), 32'd0);
        @(negedge clk_50mhz);
        check("lat_start",    32'(bus0.tx_start), 32'd1);
        check("lat_header",   32'(bus0.tx_data),  32'h22);
        wait_done(0, 8000, "ramp_done");
        check_frame(0, 256, "ramp");
        if (q0.size() > 0) check("ramp_sum_const", 32'(q0[q0.size()-1]), 32'h80);
        check("ramp_starts",   32'(starts0),       32'd258);
        check("ramp_addr_end", 32'(bus0.mem_addr), 32'd255);
        check("ramp_fin_oe",   32'(bus0.mem_oe),   32'd0);

        // Holding activate after completion: no restart, done stays high.
        repeat (30) @(negedge clk_50mhz);
        check("hold_starts", 32'(starts0),   32'd258);
        check("hold_done",   32'(bus0.done), 32'd1);
        bus0.activate = 1'b0;
        @(negedge clk_50mhz);
        check("drop_done", 32'(bus0.done), 32'd0);

        run_frame0("repeat");

        for (int i = 0; i < 256; i++) mem0[i] = 8'($urandom);
        run_frame0("rand0");

        // UART busy with another user for 50 cycles after activate.
        clear_log(0);
        force0        = 1'b1;
        bus0.activate = 1'b1;
        repeat (50) @(negedge clk_50mhz);
        check("busy_no_start", 32'(starts0),     32'd0);
        check("busy_oe",       32'(bus0.mem_oe), 32'd1);
        force0 = 1'b0;
        begin
            int k = 0;
            while (!bus0.tx_start && k < 2) begin
                @(negedge clk_50mhz);
                k++;
            end
        end
        check("busy_release_start", 32'(bus0.tx_start), 32'd1);
        wait_done(0, 8000, "busy_done");
        check_frame(0, 256, "busy");
        bus0.activate = 1'b0;
        @(negedge clk_50mhz);

        // Abort while the third data byte is in flight, then restart.
        for (int i = 0; i < 256; i++) mem0[i] = 8'($urandom);
        clear_log(0);
        bus0.activate = 1'b1;
        wait_starts0(4, 200, "abort_reach");
        bus0.activate = 1'b0;
        repeat (25) @(negedge clk_50mhz);
        check("abort_starts",   32'(starts0),       32'd4);
        check("abort_done",     32'(bus0.done),     32'd0);
        check("abort_oe",       32'(bus0.mem_oe),   32'd0);
        check("abort_tx_start", 32'(bus0.tx_start), 32'd0);
        if (q0.size() == 4) check("abort_byte3", 32'(q0[3]), 32'(mem0[2]));
        run_frame0("restart");

        // Asynchronous reset between clock edges mid-frame.
        clear_log(0);
        bus0.activate = 1'b1;
        wait_starts0(3, 200, "rst_reach");
        @(posedge clk_50mhz);
        #5;
        reset = 1'b0;
        #1;
        check("arst_done",     32'(bus0.done),     32'd0);
        check("arst_tx_start", 32'(bus0.tx_start), 32'd0);
        check("arst_oe",       32'(bus0.mem_oe),   32'd0);
        check("arst_addr",     32'(bus0.mem_addr), 32'd0);
        repeat (2) @(negedge clk_50mhz);
        clear_log(0);
        reset = 1'b1;
        wait_done(0, 8000, "arst_frame_done");
        check_frame(0, 256, "arst_frame");
        bus0.activate = 1'b0;
        @(negedge clk_50mhz);

        // COUNT=4 instance: checksum wraps, address stops at 3.
        mem1[0] = 8'hFF; mem1[1] = 8'hFF; mem1[2] = 8'h01; mem1[3] = 8'h10;
        clear_log(1);
        bus1.activate = 1'b1;
        wait_done(1, 500, "c4_done");
        check_frame(1, 4, "c4");
        if (q1.size() > 0) check("c4_sum_const", 32'(q1[q1.size()-1]), 32'h0F);
        check("c4_addr_end", 32'(bus1.mem_addr), 32'd3);
        check("c4_starts",   32'(starts1),       32'd6);
        bus1.activate = 1'b0;
        @(negedge clk_50mhz);
        check("c4_drop_done", 32'(bus1.done), 32'd0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) mem1[i] = 8'($urandom);
            clear_log(1);
            bus1.activate = 1'b1;
            wait_done(1, 500, $sformatf("c4r%0d_done", r));
            check_frame(1, 4, $sformatf("c4r%0d", r));
            bus1.activate = 1'b0;
            @(negedge clk_50mhz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
